ser_align_meas: RTL and testbench
=================================

Name: ser_align_meas

Overview:
- Parametrised symbol-error-rate measurement block.
- Auto-aligns the transmitted reference symbol stream (LFSR/mapper side) to the sliced received stream. It does this by sweeping a runtime delay line.
- Counts symbol errors over fixed windows and reports lock.
- Sits after the slicer, beside the MER error generators. Replaces fixed hand-tuned symbol delay chains and the single-bit correct/error indicator.

Parameters:
- SYM_WIDTH, 2, bits per compared symbol (2 = 4-ASK inphase, 4 = full 16-QAM).
- MAX_DELAY, 15, largest selectable alignment delay in symbols.
- DELAY_W, 4, width of delay select; must satisfy 2^DELAY_W > MAX_DELAY.
- WIN_LOG2, 10, measurement window = 2^WIN_LOG2 symbols.
- LOCK_THRESH, 16, window error count strictly below this declares lock.
- UNLOCK_THRESH, 256, window error count at or above this counts as a bad window while locked.

Ports:
- clk  in  1  system clock (sys_clk domain)
- reset  in  1  synchronous, active-high
- clk_en  in  1  symbol-rate enable (sym_clk_ena); all symbol-rate state advances only when high
- tx_sym  in  SYM_WIDTH  transmitted reference symbol
- rx_sym  in  SYM_WIDTH  sliced received symbol
- start  in  1  one-clk pulse; restarts alignment search from delay 0
- manual_mode  in  1  level; forces delay to manual_delay, search disabled
- manual_delay  in  DELAY_W  delay used in manual mode; values > MAX_DELAY clamp to MAX_DELAY
- delay_sel  out  DELAY_W  delay currently applied
- sym_error  out  1  registered per-symbol mismatch
- err_count  out  WIN_LOG2+1  error count of last completed window
- win_done  out  1  one-clk pulse when err_count updates
- locked  out  1  alignment lock
- search_wrapped  out  1  sticky: search swept all delays without lock

Behaviour:
- Reset: all outputs 0, delay line 0, FSM to SETTLE with delay_sel 0. Reset mid-window discards the partial count.
- Delay line: taps d[0..MAX_DELAY], shifted on clk_en (d[0]<=tx_sym).
  - The aligned reference is d[delay_sel], i.e. tx_sym delayed by delay_sel+1 enabled symbols.
  - sym_error <= (rx_sym != d[delay_sel]) on clk_en; it holds between enables.
- Window: symbol counter runs WIN_LOG2 bits; the error accumulator adds sym_error on each clk_en.
  - On the enable that completes 2^WIN_LOG2 symbols, err_count <= accumulator (including the current sym_error) and win_done pulses for exactly one clk.
  - On that same enable, the accumulator reloads to 0 and the symbol counter wraps to 0.
  - Full-error window gives err_count = 2^WIN_LOG2, so no overflow.
- FSM states:
  - SETTLE: after any delay change, discard 2 enabled symbols (pipeline flush). Counters are held at 0. Then go to SEARCH, or to TRACK if locked, or to MANUAL if manual_mode.
  - SEARCH: measure one window.
    - err < LOCK_THRESH: locked<=1, go to TRACK.
    - Otherwise: delay_sel+1, go to SETTLE. At MAX_DELAY, wrap to 0 and set search_wrapped.
  - TRACK: continuous windows.
    - Two consecutive windows with err >= UNLOCK_THRESH: locked<=0, delay_sel+1 (with wrap), go to SETTLE, then SEARCH.
    - A single bad window followed by a good window clears the bad-window count.
  - MANUAL: entered from any state when manual_mode=1 (via SETTLE). delay_sel = clamped manual_delay; locked=0; windows run continuously.
    - A change of manual_delay re-enters SETTLE.
    - Deasserting manual_mode: delay_sel<=0, go to SETTLE, then SEARCH.
- start: delay_sel<=0, locked<=0, search_wrapped<=0, go to SETTLE. Ignored while manual_mode=1.
- Simultaneous events take priority in this order: reset > manual_mode > start > window completion.
- win_done and err_count continue to update in every state except SETTLE.

Optional Feature:
- Macro SER_ALIGN_TOTALS_EN.
- When defined, adds outputs total_errs [31:0] and total_syms [31:0], saturating at 2^32-1.
  - Both count every enabled symbol outside SETTLE.
  - Both clear on reset and start.
  - They do not affect the FSM.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Defaults, rx_sym = tx_sym delayed 4 symbols, error-free -> delay_sel steps 0,1,2,3, then locked=1 at delay_sel=3 after the 4th search window; err_count=0 on the lock window.
- Locked at delay 3, inject 300 random symbol errors per window for 2 windows -> locked falls after the 2nd win_done; delay_sel=4; search resumes and re-locks at 3 after wrapping, with search_wrapped=1.
- Uncorrelated rx_sym (independent LFSR) -> search_wrapped=1 after 16 windows; locked stays 0; err_count ≈ 768 (±64) for SYM_WIDTH=2.
- manual_mode=1, manual_delay=20 with delay 3 truth -> delay_sel=15 (clamped), locked=0, err_count ≈ 768. Then manual_delay=3 -> next full window err_count=0.
- Exactly 5 injected errors in one window while locked -> err_count=5, win_done one clk wide, locked stays 1. Reset mid-window -> all outputs 0 next clk, first post-reset win_done only after SETTLE plus a full window.
- With SER_ALIGN_TOTALS_EN, 3 windows error-free after lock -> total_syms increments by exactly 3072 and total_errs is unchanged; start clears both to 0.

Source files
------------

// File: rtl/ser_align_meas.sv
// Symbol-error-rate measurement with automatic reference/received stream alignment.
// Optional saturating lifetime totals are enabled by defining SER_ALIGN_TOTALS_EN.
module ser_align_meas #(
  parameter int unsigned SYM_WIDTH     = 2,
  parameter int unsigned MAX_DELAY     = 15,
  parameter int unsigned DELAY_W       = 4,
  parameter int unsigned WIN_LOG2      = 10,
  parameter int unsigned LOCK_THRESH   = 16,
  parameter int unsigned UNLOCK_THRESH = 256
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clk_en,
  input  logic [SYM_WIDTH-1:0] tx_sym,
  input  logic [SYM_WIDTH-1:0] rx_sym,
  input  logic                 start,
  input  logic                 manual_mode,
  input  logic [DELAY_W-1:0]   manual_delay,
  output logic [DELAY_W-1:0]   delay_sel,
  output logic                 sym_error,
  output logic [WIN_LOG2:0]    err_count,
  output logic                 win_done,
  output logic                 locked,
`ifdef SER_ALIGN_TOTALS_EN
  output logic                 search_wrapped,
  output logic [31:0]          total_errs,
  output logic [31:0]          total_syms
`else
  output logic                 search_wrapped
`endif
);

  typedef enum logic [1:0] {ST_SETTLE, ST_SEARCH, ST_TRACK, ST_MANUAL} state_t;

  localparam int unsigned IDX_W = (MAX_DELAY > 0) ? $clog2(MAX_DELAY + 1) : 1;
  localparam logic [DELAY_W-1:0] LP_MAX    = DELAY_W'(MAX_DELAY);
  localparam logic [WIN_LOG2:0]  LP_LOCK   = (WIN_LOG2 + 1)'(LOCK_THRESH);
  localparam logic [WIN_LOG2:0]  LP_UNLOCK = (WIN_LOG2 + 1)'(UNLOCK_THRESH);

  state_t                r_state, w_state_nxt;
  logic [DELAY_W-1:0]    r_delay, w_delay_nxt, w_man_delay, w_delay_inc;
  logic                  r_locked, w_locked_nxt;
  logic                  r_wrapped, w_wrapped_nxt;
  logic                  r_settle, w_settle_nxt;
  logic                  r_bad, w_bad_nxt;

  logic [SYM_WIDTH-1:0]  r_dline [MAX_DELAY+1];
  logic                  r_sym_err;
  logic [WIN_LOG2-1:0]   r_sym_cnt;
  logic [WIN_LOG2:0]     r_acc, r_err_count, w_win_err;
  logic                  r_win_done;
  logic                  w_win_end, w_start;
  logic [IDX_W-1:0]      w_tap;

  assign w_man_delay = (manual_delay > LP_MAX) ? LP_MAX : manual_delay;
  assign w_delay_inc = (r_delay == LP_MAX) ? '0 : r_delay + DELAY_W'(1);
  assign w_tap       = r_delay[IDX_W-1:0];
  assign w_win_end   = clk_en && (r_state != ST_SETTLE) && (r_sym_cnt == '1);
  assign w_win_err   = r_acc + (WIN_LOG2 + 1)'(r_sym_err);
  assign w_start     = start && !manual_mode;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i <= MAX_DELAY; i++) r_dline[i] <= '0;
      r_sym_err <= 1'b0;
    end else if (clk_en) begin
      r_dline[0] <= tx_sym;
      for (int unsigned i = 1; i <= MAX_DELAY; i++) r_dline[i] <= r_dline[i-1];
      r_sym_err <= (rx_sym != r_dline[w_tap]);
    end
  end

  // The accumulator lags the compare by one symbol, so the closing window adds the live sym_error.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sym_cnt   <= '0;
      r_acc       <= '0;
      r_err_count <= '0;
      r_win_done  <= 1'b0;
    end else begin
      r_win_done <= 1'b0;
      if (r_state == ST_SETTLE) begin
        r_sym_cnt <= '0;
        r_acc     <= '0;
      end else if (clk_en) begin
        if (r_sym_cnt == '1) begin
          r_err_count <= w_win_err;
          r_win_done  <= 1'b1;
          r_acc       <= '0;
          r_sym_cnt   <= '0;
        end else begin
          r_acc     <= w_win_err;
          r_sym_cnt <= r_sym_cnt + WIN_LOG2'(1);
        end
      end
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_delay_nxt   = r_delay;
    w_locked_nxt  = r_locked;
    w_wrapped_nxt = r_wrapped;
    w_settle_nxt  = r_settle;
    w_bad_nxt     = r_bad;
    if (manual_mode) begin
      w_locked_nxt = 1'b0;
      w_bad_nxt    = 1'b0;
      if ((r_delay != w_man_delay) || (r_state == ST_SEARCH) || (r_state == ST_TRACK)) begin
        w_delay_nxt  = w_man_delay;
        w_state_nxt  = ST_SETTLE;
        w_settle_nxt = 1'b0;
      end else if ((r_state == ST_SETTLE) && clk_en) begin
        if (r_settle) begin
          w_state_nxt  = ST_MANUAL;
          w_settle_nxt = 1'b0;
        end else begin
          w_settle_nxt = 1'b1;
        end
      end
    end else if ((r_state == ST_MANUAL) || w_start) begin
      w_delay_nxt  = '0;
      w_locked_nxt = 1'b0;
      w_bad_nxt    = 1'b0;
      w_state_nxt  = ST_SETTLE;
      w_settle_nxt = 1'b0;
      if (w_start) w_wrapped_nxt = 1'b0;
    end else begin
      case (r_state)
        ST_SETTLE: begin
          if (clk_en) begin
            if (r_settle) begin
              w_settle_nxt = 1'b0;
              w_state_nxt  = r_locked ? ST_TRACK : ST_SEARCH;
            end else begin
              w_settle_nxt = 1'b1;
            end
          end
        end
        ST_SEARCH: begin
          if (w_win_end) begin
            if (w_win_err < LP_LOCK) begin
              w_locked_nxt = 1'b1;
              w_bad_nxt    = 1'b0;
              w_state_nxt  = ST_TRACK;
            end else begin
              w_delay_nxt  = w_delay_inc;
              if (r_delay == LP_MAX) w_wrapped_nxt = 1'b1;
              w_state_nxt  = ST_SETTLE;
              w_settle_nxt = 1'b0;
            end
          end
        end
        ST_TRACK: begin
          if (w_win_end) begin
            if (w_win_err >= LP_UNLOCK) begin
              if (r_bad) begin
                w_locked_nxt = 1'b0;
                w_bad_nxt    = 1'b0;
                w_delay_nxt  = w_delay_inc;
                w_state_nxt  = ST_SETTLE;
                w_settle_nxt = 1'b0;
              end else begin
                w_bad_nxt = 1'b1;
              end
            end else begin
              w_bad_nxt = 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_SETTLE;
      r_delay   <= '0;
      r_locked  <= 1'b0;
      r_wrapped <= 1'b0;
      r_settle  <= 1'b0;
      r_bad     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_delay   <= w_delay_nxt;
      r_locked  <= w_locked_nxt;
      r_wrapped <= w_wrapped_nxt;
      r_settle  <= w_settle_nxt;
      r_bad     <= w_bad_nxt;
    end
  end

  assign delay_sel      = r_delay;
  assign sym_error      = r_sym_err;
  assign err_count      = r_err_count;
  assign win_done       = r_win_done;
  assign locked         = r_locked;
  assign search_wrapped = r_wrapped;

`ifdef SER_ALIGN_TOTALS_EN
  logic [31:0] r_total_errs, r_total_syms;

  always_ff @(posedge clk) begin
    if (reset || w_start) begin
      r_total_errs <= '0;
      r_total_syms <= '0;
    end else if (clk_en && (r_state != ST_SETTLE)) begin
      if (r_total_syms != '1) r_total_syms <= r_total_syms + 32'd1;
      if (r_sym_err && (r_total_errs != '1)) r_total_errs <= r_total_errs + 32'd1;
    end
  end

  assign total_errs = r_total_errs;
  assign total_syms = r_total_syms;
`endif

endmodule

// File: tb/tb_ser_align_meas.sv
// Directed bench for ser_align_meas: reset, search/lock, track/unlock, manual clamp, gated windows.
// DELAY_W is widened to 5 so an out-of-range manual delay (20) can be presented and clamped.
module tb_ser_align_meas;
  localparam int unsigned SW = 2;
  localparam int unsigned DW = 5;
  localparam int unsigned WL = 10;

  logic          clk = 1'b0;
  logic          reset, clk_en, start, manual_mode;
  logic [SW-1:0] tx_sym, rx_sym;
  logic [DW-1:0] manual_delay, delay_sel;
  logic          sym_error, win_done, locked, search_wrapped;
  logic [WL:0]   err_count;
`ifdef SER_ALIGN_TOTALS_EN
  logic [31:0]   total_errs, total_syms;
`endif

  int unsigned   total = 0;
  int unsigned   bad = 0;
  int unsigned   nen = 0;
  logic [SW-1:0] hist [4];

  ser_align_meas #(
    .SYM_WIDTH(SW), .MAX_DELAY(15), .DELAY_W(DW), .WIN_LOG2(WL),
    .LOCK_THRESH(16), .UNLOCK_THRESH(256)
  ) dut (
    .clk(clk), .reset(reset), .clk_en(clk_en), .tx_sym(tx_sym), .rx_sym(rx_sym),
    .start(start), .manual_mode(manual_mode), .manual_delay(manual_delay),
    .delay_sel(delay_sel), .sym_error(sym_error), .err_count(err_count),
    .win_done(win_done), .locked(locked),
`ifdef SER_ALIGN_TOTALS_EN
    .search_wrapped(search_wrapped), .total_errs(total_errs), .total_syms(total_syms)
`else
    .search_wrapped(search_wrapped)
`endif
  );

  always #5 clk = ~clk;

  // rx is tx from four enabled symbols earlier (true alignment delay_sel = 3) unless rnd.
  task automatic step(input logic en, input logic inj, input logic rnd);
    clk_en = en;
    if (en) begin
      tx_sym = SW'($urandom);
      if (rnd) rx_sym = SW'($urandom);
      else begin
        rx_sym = hist[3];
        if (inj) rx_sym = rx_sym ^ SW'($urandom_range(1, 3));
      end
      hist[3] = hist[2]; hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = tx_sym;
      nen++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_win(input int unsigned lo, input int unsigned hi, input logic rnd,
                         input logic gate, output int unsigned clks);
    int unsigned ei;
    logic en;
    clks = 0;
    ei = 0;
    do begin
      en = gate ? clks[0] : 1'b1;
      if (en) ei++;
      step(en, en && (ei >= lo) && (ei <= hi), rnd);
      clks++;
    end while (!win_done && clks < 2300);
    if (!win_done) begin
      total++; bad++;
      $display("FAIL win_timeout: no win_done after %0d clks, required within 2300", clks);
    end
  endtask

  task automatic test_reset;
    int unsigned c;
    reset = 1'b1; start = 1'b0; manual_mode = 1'b0; manual_delay = '0;
    tx_sym = '0; rx_sym = '0;
    for (int i = 0; i < 4; i++) hist[i] = '0;
    repeat (3) step(1'b1, 1'b0, 1'b0);
    total++;
    if ({delay_sel, sym_error, err_count, win_done, locked, search_wrapped} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: delay=%0d err=%0b cnt=%0d done=%0b lock=%0b wrap=%0b, required all 0",
               delay_sel, sym_error, err_count, win_done, locked, search_wrapped);
    end
    reset = 1'b0;
    nen = 0;
    run_win(1, 0, 1'b0, 1'b0, c);
    total++;
    if (nen !== 1026) begin
      bad++; $display("FAIL first_win_latency: got %0d enables, required 1026", nen);
    end
    total++;
    if (delay_sel !== 5'd1 || locked !== 1'b0) begin
      bad++; $display("FAIL first_win_step: delay=%0d lock=%0b, required delay=1 lock=0", delay_sel, locked);
    end
  endtask

  task automatic test_search_lock;
    int unsigned c;
    start = 1'b1; step(1'b1, 1'b0, 1'b0); start = 1'b0;
    total++;
    if (delay_sel !== 5'd0 || locked !== 1'b0 || search_wrapped !== 1'b0) begin
      bad++; $display("FAIL start_clear: delay=%0d lock=%0b wrap=%0b, required 0 0 0",
                      delay_sel, locked, search_wrapped);
    end
    for (int unsigned w = 1; w <= 4; w++) begin
      run_win(1, 0, 1'b0, 1'b0, c);
      total++;
      if (w < 4) begin
        if (delay_sel !== DW'(w) || locked !== 1'b0 || err_count < 16) begin
          bad++; $display("FAIL search_step%0d: delay=%0d lock=%0b err=%0d, required delay=%0d lock=0 err>=16",
                          w, delay_sel, locked, err_count, w);
        end
      end else if (delay_sel !== 5'd3 || locked !== 1'b1 || err_count !== '0) begin
        bad++; $display("FAIL search_lock: delay=%0d lock=%0b err=%0d, required delay=3 lock=1 err=0",
                        delay_sel, locked, err_count);
      end
    end
  endtask

  task automatic test_track_unlock;
    int unsigned c, nw;
    logic [3:0]  injw = 4'b1101;
    logic [3:0]  explock = 4'b0111;
    for (int unsigned w = 0; w < 4; w++) begin
      run_win(10, injw[w] ? 309 : 0, 1'b0, 1'b0, c);
      total++;
      if (locked !== explock[w] || err_count !== (injw[w] ? 11'd300 : 11'd0) ||
          delay_sel !== (explock[w] ? 5'd3 : 5'd4)) begin
        bad++; $display("FAIL track_win%0d: lock=%0b err=%0d delay=%0d, required lock=%0b err=%0d delay=%0d",
                        w, locked, err_count, delay_sel, explock[w], injw[w] ? 300 : 0, explock[w] ? 3 : 4);
      end
    end
    total++;
    if (search_wrapped !== 1'b0) begin
      bad++; $display("FAIL unlock_wrap: wrap=%0b, required 0", search_wrapped);
    end
    nw = 0;
    do begin
      run_win(1, 0, 1'b0, 1'b0, c);
      nw++;
    end while (!locked && nw < 20);
    total++;
    if (nw !== 16 || delay_sel !== 5'd3 || search_wrapped !== 1'b1) begin
      bad++; $display("FAIL relock: windows=%0d delay=%0d wrap=%0b, required 16 3 1", nw, delay_sel, search_wrapped);
    end
  endtask

  task automatic test_uncorrelated;
    int unsigned c;
    start = 1'b1; step(1'b1, 1'b0, 1'b1); start = 1'b0;
    for (int unsigned w = 1; w <= 16; w++) begin
      run_win(1, 0, 1'b1, 1'b0, c);
      total++;
      if (err_count < 704 || err_count > 832 || locked !== 1'b0) begin
        bad++; $display("FAIL uncorr_win%0d: err=%0d lock=%0b, required 704..832 lock=0", w, err_count, locked);
      end
      if (w == 15) begin
        total++;
        if (search_wrapped !== 1'b0) begin
          bad++; $display("FAIL uncorr_wrap_early: wrap=%0b, required 0", search_wrapped);
        end
      end
    end
    total++;
    if (search_wrapped !== 1'b1 || delay_sel !== 5'd0) begin
      bad++; $display("FAIL uncorr_wrap: wrap=%0b delay=%0d, required 1 0", search_wrapped, delay_sel);
    end
  endtask

  task automatic test_manual;
    int unsigned c, nw;
    manual_mode = 1'b1; manual_delay = 5'd20;
    step(1'b1, 1'b0, 1'b0);
    total++;
    if (delay_sel !== 5'd15 || locked !== 1'b0) begin
      bad++; $display("FAIL manual_clamp: delay=%0d lock=%0b, required 15 0", delay_sel, locked);
    end
    run_win(1, 0, 1'b0, 1'b0, c);
    total++;
    if (err_count < 704 || err_count > 832 || delay_sel !== 5'd15) begin
      bad++; $display("FAIL manual_win15: err=%0d delay=%0d, required 704..832 15", err_count, delay_sel);
    end
    manual_delay = 5'd3;
    step(1'b1, 1'b0, 1'b0);
    run_win(1, 0, 1'b0, 1'b0, c);
    total++;
    if (err_count !== '0 || delay_sel !== 5'd3 || locked !== 1'b0) begin
      bad++; $display("FAIL manual_win3: err=%0d delay=%0d lock=%0b, required 0 3 0", err_count, delay_sel, locked);
    end
    start = 1'b1; step(1'b1, 1'b0, 1'b0); start = 1'b0;
    total++;
    if (delay_sel !== 5'd3 || search_wrapped !== 1'b1) begin
      bad++; $display("FAIL manual_start_ignored: delay=%0d wrap=%0b, required 3 1", delay_sel, search_wrapped);
    end
    manual_mode = 1'b0;
    step(1'b1, 1'b0, 1'b0);
    total++;
    if (delay_sel !== 5'd0 || locked !== 1'b0) begin
      bad++; $display("FAIL manual_exit: delay=%0d lock=%0b, required 0 0", delay_sel, locked);
    end
    nw = 0;
    do begin
      run_win(1, 0, 1'b0, 1'b0, c);
      nw++;
    end while (!locked && nw < 6);
    total++;
    if (nw !== 4 || delay_sel !== 5'd3 || locked !== 1'b1) begin
      bad++; $display("FAIL manual_relock: windows=%0d delay=%0d lock=%0b, required 4 3 1", nw, delay_sel, locked);
    end
  endtask

  task automatic test_gated_errors;
    int unsigned c;
    run_win(100, 104, 1'b0, 1'b1, c);
    total++;
    if (c !== 2048 || err_count !== 11'd5 || locked !== 1'b1) begin
      bad++; $display("FAIL gated_five: clks=%0d err=%0d lock=%0b, required 2048 5 1", c, err_count, locked);
    end
    step(1'b0, 1'b0, 1'b0);
    total++;
    if (win_done !== 1'b0 || err_count !== 11'd5 || locked !== 1'b1) begin
      bad++; $display("FAIL done_width: done=%0b err=%0d lock=%0b, required 0 5 1", win_done, err_count, locked);
    end
  endtask

`ifdef SER_ALIGN_TOTALS_EN
  task automatic test_totals;
    int unsigned c;
    logic [31:0] s0, e0;
    run_win(1, 0, 1'b0, 1'b0, c);
    s0 = total_syms; e0 = total_errs;
    repeat (3) run_win(1, 0, 1'b0, 1'b0, c);
    total++;
    if (total_syms - s0 !== 32'd3072 || total_errs !== e0) begin
      bad++; $display("FAIL totals_delta: syms+%0d errs=%0d, required +3072 errs=%0d", total_syms - s0, total_errs, e0);
    end
    start = 1'b1; step(1'b1, 1'b0, 1'b0); start = 1'b0;
    total++;
    if (total_syms !== '0 || total_errs !== '0) begin
      bad++; $display("FAIL totals_start: syms=%0d errs=%0d, required 0 0", total_syms, total_errs);
    end
  endtask
`endif

  task automatic test_reset_mid;
    int unsigned c;
    repeat (500) step(1'b1, 1'b0, 1'b0);
    reset = 1'b1;
    step(1'b1, 1'b0, 1'b0);
    total++;
    if ({delay_sel, sym_error, err_count, win_done, locked, search_wrapped} !== '0) begin
      bad++; $display("FAIL midreset_outputs: delay=%0d err=%0b cnt=%0d done=%0b lock=%0b wrap=%0b, required all 0",
                      delay_sel, sym_error, err_count, win_done, locked, search_wrapped);
    end
    reset = 1'b0;
    nen = 0;
    run_win(1, 0, 1'b0, 1'b0, c);
    total++;
    if (nen !== 1026 || delay_sel !== 5'd1) begin
      bad++; $display("FAIL midreset_latency: enables=%0d delay=%0d, required 1026 1", nen, delay_sel);
    end
  endtask

  initial begin
    test_reset;
    test_search_lock;
    test_track_unlock;
    test_uncorrelated;
    test_manual;
    test_gated_errors;
`ifdef SER_ALIGN_TOTALS_EN
    test_totals;
`endif
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
